// File: rtl/simple_pll_pkg.sv
// Shared types and constants for the simple PLL lock detector.
package simple_pll_pkg;

    // Lock-detector FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } lock_state_t;

    // Width of the optional bad-period / timeout statistics counter
    localparam int ERR_COUNT_W = 16;

endpackage : simple_pll_pkg

// File: rtl/simple_pll_sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the in_clock
// domain. Both flops clear to 0 on a synchronous active-high reset.
module simple_pll_sync2 (
    input  logic in_clock,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    // Two-stage resynchronization of the asynchronous input
    always_ff @(posedge in_clock) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule : simple_pll_sync2

// File: rtl/simple_pll_lock_detect.sv
// Lock detector for the divided PLL clock. pll_clock is sampled as data in
// the in_clock domain; the number of in_clock cycles between its rising
// edges is measured, and locked asserts after LOCK_COUNT consecutive
// in-tolerance periods.
// Optional feature macro: SIMPLE_PLL_LOCK_STATS_EN adds the err_count port,
// a saturating count of bad periods and timeouts seen outside IDLE.
module simple_pll_lock_detect
    import simple_pll_pkg::*;
#(
    parameter int PERIOD_W        = 8,
    parameter int EXPECTED_PERIOD = 64,
    parameter int TOLERANCE       = 1,
    parameter int LOCK_COUNT      = 4,
    parameter int LOCK_W          = 3
) (
    input  logic                   in_clock,
    input  logic                   reset,
    input  logic                   pll_clock,
    output logic                   locked,
    output logic [PERIOD_W-1:0]    period,
    output logic                   period_valid,
`ifdef SIMPLE_PLL_LOCK_STATS_EN
    output logic                   lock_lost,
    output logic [ERR_COUNT_W-1:0] err_count
`else
    output logic                   lock_lost
`endif
);

    // Constants sized to the arithmetic they take part in; the tolerance
    // window is evaluated one bit wider than the counter so it cannot wrap.
    localparam logic [PERIOD_W:0]   EXP_W       = (PERIOD_W+1)'(EXPECTED_PERIOD);
    localparam logic [PERIOD_W:0]   TOL_W       = (PERIOD_W+1)'(TOLERANCE);
    localparam logic [PERIOD_W-1:0] TIMEOUT_CNT = PERIOD_W'(EXPECTED_PERIOD + TOLERANCE);
    localparam logic [LOCK_W-1:0]   LOCK_TGT    = LOCK_W'(LOCK_COUNT);

    // Saturating increment of the period counter
    function automatic logic [PERIOD_W-1:0] sat_inc_period(input logic [PERIOD_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic                w_s2;
    logic                r_s3;
    logic                w_edge;
    logic [PERIOD_W-1:0] r_period_cnt;
    logic [PERIOD_W:0]   w_meas;
    logic                w_good;
    logic                w_timeout;

    lock_state_t         r_state;
    lock_state_t         w_next_state;
    logic [LOCK_W-1:0]   r_good_cnt;
    logic [LOCK_W-1:0]   w_next_good;
    logic [LOCK_W-1:0]   w_good_inc;
    logic                r_locked;
    logic                w_next_locked;
    logic                r_lock_lost;
    logic                w_lock_lost_d;
    logic                r_period_valid;
    logic                w_period_upd;
    logic [PERIOD_W-1:0] r_period;

    simple_pll_sync2 u_sync (
        .in_clock (in_clock),
        .reset    (reset),
        .i_d      (pll_clock),
        .o_q      (w_s2)
    );

    // History flop for rising-edge detection after the synchronizer
    always_ff @(posedge in_clock) begin
        if (reset) begin
            r_s3 <= 1'b0;
        end else begin
            r_s3 <= w_s2;
        end
    end

    assign w_edge     = w_s2 & ~r_s3;
    assign w_meas     = {1'b0, r_period_cnt} + 1'b1;
    assign w_good     = (w_meas >= EXP_W) ? ((w_meas - EXP_W) <= TOL_W)
                                          : ((EXP_W - w_meas) <= TOL_W);
    // A coincident edge takes priority, so timeout only exists without one
    assign w_timeout  = ~w_edge & (r_period_cnt == TIMEOUT_CNT);
    assign w_good_inc = r_good_cnt + 1'b1;

    // Next-state, good-period count and lock-flag decisions
    always_comb begin
        w_next_state  = r_state;
        w_next_good   = r_good_cnt;
        w_next_locked = r_locked;
        w_lock_lost_d = 1'b0;
        w_period_upd  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_edge) begin
                    w_next_state = ACQUIRE;
                    w_next_good  = '0;
                end
            end
            ACQUIRE: begin
                if (w_edge) begin
                    w_period_upd = 1'b1;
                    if (w_good) begin
                        w_next_good = w_good_inc;
                        if (w_good_inc == LOCK_TGT) begin
                            w_next_state  = LOCKED;
                            w_next_locked = 1'b1;
                        end
                    end else begin
                        w_next_good = '0;
                    end
                end else if (w_timeout) begin
                    w_next_state = IDLE;
                end
            end
            LOCKED: begin
                if (w_edge) begin
                    w_period_upd = 1'b1;
                    if (!w_good) begin
                        w_next_state  = ACQUIRE;
                        w_next_good   = '0;
                        w_next_locked = 1'b0;
                        w_lock_lost_d = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_next_state  = IDLE;
                    w_next_locked = 1'b0;
                    w_lock_lost_d = 1'b1;
                end
            end
            default: begin
                w_next_state  = IDLE;
                w_next_good   = '0;
                w_next_locked = 1'b0;
            end
        endcase
    end

    // FSM state and registered lock flags
    always_ff @(posedge in_clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_good_cnt  <= '0;
            r_locked    <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_good_cnt  <= w_next_good;
            r_locked    <= w_next_locked;
            r_lock_lost <= w_lock_lost_d;
        end
    end

    // Period counter and measured-period register
    always_ff @(posedge in_clock) begin
        if (reset) begin
            r_period_cnt   <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
        end else begin
            r_period_cnt   <= w_edge ? '0 : sat_inc_period(r_period_cnt);
            r_period_valid <= w_period_upd;
            if (w_period_upd) begin
                r_period <= w_meas[PERIOD_W-1:0];
            end
        end
    end

`ifdef SIMPLE_PLL_LOCK_STATS_EN
    logic [ERR_COUNT_W-1:0] r_err_count;
    logic                   w_err_hit;

    // Saturating increment of the error statistics counter
    function automatic logic [ERR_COUNT_W-1:0] sat_inc_err(input logic [ERR_COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_err_hit = (r_state != IDLE) & ((w_edge & ~w_good) | w_timeout);

    // Count bad periods and timeouts while acquiring or locked
    always_ff @(posedge in_clock) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_err_hit) begin
            r_err_count <= sat_inc_err(r_err_count);
        end
    end

    assign err_count = r_err_count;
`endif

    assign locked       = r_locked;
    assign lock_lost    = r_lock_lost;
    assign period       = r_period;
    assign period_valid = r_period_valid;

endmodule : simple_pll_lock_detect
